vtm_seq: RTL

Run-control sequencer for the native video timing generator (vtm). It turns start/stop commands into the generator's `i_vtm_en`, so a run is either a fixed number of frames or continuous and always ends on a frame boundary. It also drives `i_vtm_pau` from downstream readiness during h-blank, using a bounded pause with timeout for FLEX_HBLK builds. It sits between the register/control layer and the vtm instance in the pclk domain.

---
 rtl/vtm_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vtm_seq.sv
// Run-control sequencer for the vtm video timing generator: frame-bounded
// enable sequencing plus h-blank pause with a per-line timeout.
module vtm_seq #(
  parameter int unsigned FM_WID  = 8,
  parameter int unsigned PAU_TMO = 1023
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [FM_WID-1:0] i_fm_num,
  input  logic              i_ds_rdy,
  input  logic              i_vtm_fstr,
  input  logic              i_vtm_fend,
  input  logic              i_vtm_hstr,
  input  logic              i_vtm_hend,
  input  logic              i_vtm_vend,
  output logic              o_vtm_en,
  output logic              o_vtm_pau,
  output logic              o_busy,
  output logic              o_done,
  output logic [FM_WID-1:0] o_fm_cnt,
  output logic              o_err
);

  localparam int unsigned PC_WID = $clog2(PAU_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [FM_WID-1:0]   fm_req;
  logic [FM_WID-1:0]   fm_req_nxt;
  logic [FM_WID-1:0]   fs_cnt;
  logic [FM_WID-1:0]   fs_cnt_nxt;
  logic [FM_WID-1:0]   fs_cnt_inc;
  logic [FM_WID-1:0]   fm_cnt_nxt;
  logic [PC_WID-1:0]   pau_cnt;
  logic [PC_WID-1:0]   pau_cnt_nxt;
  logic                in_hblk;
  logic                in_hblk_nxt;
  logic                tmo_hit;
  logic                tmo_hit_nxt;
  logic                en_nxt;
  logic                pau_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                err_nxt;
  logic                start_acc;
  logic                fs_last;
  logic                tmo_now;

  assign start_acc  = (state == S_IDLE) && i_start;
  assign fs_cnt_inc = fs_cnt + FM_WID'(1);
  assign fs_last    = i_vtm_fstr && (fm_req != '0) && (fs_cnt_inc == fm_req);
  // Last permitted pause cycle of this h-blank is the one being driven now
  assign tmo_now    = o_vtm_pau && (pau_cnt == PC_WID'(PAU_TMO - 1));

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (i_start) state_nxt = S_RUN;
      S_RUN:   if (i_stop || fs_last) state_nxt = S_DRAIN;
      S_DRAIN: if (i_vtm_fend) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fm_req_nxt  = fm_req;
    fs_cnt_nxt  = fs_cnt;
    fm_cnt_nxt  = o_fm_cnt;
    err_nxt     = o_err;
    in_hblk_nxt = in_hblk;
    tmo_hit_nxt = tmo_hit;
    pau_cnt_nxt = pau_cnt;

    if (start_acc) begin
      fm_req_nxt = i_fm_num;
      fs_cnt_nxt = '0;
      fm_cnt_nxt = '0;
      err_nxt    = 1'b0;
    end else begin
      if ((state == S_RUN) && i_vtm_fstr) fs_cnt_nxt = fs_cnt_inc;
      if (o_busy && i_vtm_fend)           fm_cnt_nxt = o_fm_cnt + FM_WID'(1);
      if (tmo_now)                        err_nxt    = 1'b1;
    end

    // vend-line hend never opens a pausable h-blank
    if ((state == S_IDLE) || i_vtm_hstr || i_vtm_fend) in_hblk_nxt = 1'b0;
    else if (i_vtm_hend && !i_vtm_vend)                in_hblk_nxt = 1'b1;

    if ((state == S_IDLE) || i_vtm_hstr) begin
      pau_cnt_nxt = '0;
      tmo_hit_nxt = 1'b0;
    end else begin
      if (o_vtm_pau) pau_cnt_nxt = pau_cnt + PC_WID'(1);
      if (tmo_now)   tmo_hit_nxt = 1'b1;
    end

    pau_nxt  = in_hblk_nxt && !i_ds_rdy && !tmo_hit && !tmo_now && o_busy;
    en_nxt   = (state_nxt == S_RUN);
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      fm_req    <= '0;
      fs_cnt    <= '0;
      pau_cnt   <= '0;
      in_hblk   <= 1'b0;
      tmo_hit   <= 1'b0;
      o_vtm_en  <= 1'b0;
      o_vtm_pau <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_fm_cnt  <= '0;
      o_err     <= 1'b0;
    end else begin
      fm_req    <= fm_req_nxt;
      fs_cnt    <= fs_cnt_nxt;
      pau_cnt   <= pau_cnt_nxt;
      in_hblk   <= in_hblk_nxt;
      tmo_hit   <= tmo_hit_nxt;
      o_vtm_en  <= en_nxt;
      o_vtm_pau <= pau_nxt;
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
      o_fm_cnt  <= fm_cnt_nxt;
      o_err     <= err_nxt;
    end
  end

endmodule
